operand_fwd_ctrl: RTL and testbench

- Parametrised decode-stage operand unit: selects ALU operands A/B and forwards in-flight results from any of NUM_STAGES downstream pipeline stages.
- Holds an internal in-flight write tracker (shift register), so the downstream pipeline supplies only per-stage result data and ready flags; it does not supply per-stage rd/rwe.
- Detects load-use hazards, where the producer's data is not yet available, and stalls decode.
- Sits between register-file read and the execute stage.

---
 rtl/operand_fwd_ctrl.sv | 131 +++++++++++++
 tb/tb_operand_fwd_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/operand_fwd_ctrl.sv
// Decode-stage operand select with multi-stage result forwarding and load-use stall.
// Define OPERAND_FWD_STALL_CNT_EN to add the saturating stall_cnt output.
module operand_fwd_ctrl #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     id_valid,
  input  logic [6:0]               id_opcode,
  input  logic [4:0]               id_rs1,
  input  logic [4:0]               id_rs2,
  input  logic [4:0]               id_rd,
  input  logic                     id_rwe,
  input  logic [XLEN-1:0]          id_rs1d,
  input  logic [XLEN-1:0]          id_rs2d,
  input  logic [XLEN-1:0]          id_pc,
  input  logic [XLEN-1:0]          id_imm,
  input  logic [NUM_STAGES*XLEN-1:0] stg_data,
  input  logic [NUM_STAGES-1:0]    stg_ready,
  input  logic                     flush,
  output logic                     stall,
  output logic                     issue,
  output logic [XLEN-1:0]          rs1d_fwd,
  output logic [XLEN-1:0]          rs2d_fwd,
  output logic [XLEN-1:0]          op_a,
  output logic [XLEN-1:0]          op_b
`ifdef OPERAND_FWD_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  logic [NUM_STAGES-1:0] trk_vld;
  logic [4:0]            trk_rd  [NUM_STAGES];
  logic                  trk_rwe [NUM_STAGES];

  logic rs1_haz, rs2_haz;
  logic rs1_used, rs2_used;
  logic sel_a, sel_b;

  function automatic logic entry_hit(input logic v, input logic rwe,
                                     input logic [4:0] rd, input logic [4:0] src);
    return v & rwe & (rd != 5'd0) & (rd == src);
  endfunction

  // Forward resolve: scan oldest to youngest so the youngest match overrides.
  always_comb begin
    rs1d_fwd = id_rs1d;
    rs2d_fwd = id_rs2d;
    rs1_haz  = 1'b0;
    rs2_haz  = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (entry_hit(trk_vld[k], trk_rwe[k], trk_rd[k], id_rs1)) begin
        rs1d_fwd = stg_data[k*XLEN +: XLEN];
        rs1_haz  = ~stg_ready[k];
      end
      if (entry_hit(trk_vld[k], trk_rwe[k], trk_rd[k], id_rs2)) begin
        rs2d_fwd = stg_data[k*XLEN +: XLEN];
        rs2_haz  = ~stg_ready[k];
      end
    end
  end

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    sel_a    = 1'b0;
    sel_b    = 1'b0;
    case (id_opcode)
      OPC_ARI_RTYPE: begin rs1_used = 1'b1; rs2_used = 1'b1; end
      OPC_ARI_ITYPE: begin rs1_used = 1'b1; sel_b = 1'b1; end
      OPC_LOAD:      begin rs1_used = 1'b1; sel_b = 1'b1; end
      OPC_STORE:     begin rs1_used = 1'b1; rs2_used = 1'b1; sel_b = 1'b1; end
      OPC_BRANCH:    begin rs1_used = 1'b1; rs2_used = 1'b1; sel_a = 1'b1; sel_b = 1'b1; end
      OPC_JALR:      begin rs1_used = 1'b1; sel_b = 1'b1; end
      OPC_JAL:       begin sel_a = 1'b1; sel_b = 1'b1; end
      OPC_LUI:       sel_b = 1'b1;
      OPC_AUIPC:     begin sel_a = 1'b1; sel_b = 1'b1; end
      default:       ;
    endcase
  end

  assign stall = id_valid & ((rs1_used & rs1_haz) | (rs2_used & rs2_haz)) & ~flush;
  assign issue = id_valid & ~stall & ~flush;
  assign op_a  = sel_a ? id_pc  : rs1d_fwd;
  assign op_b  = sel_b ? id_imm : rs2d_fwd;

  // Tracker stage boundary: valid bits are control and reset; rd/rwe only matter when valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trk_vld <= '0;
    end else if (flush) begin
      trk_vld <= '0;
    end else begin
      trk_vld[0] <= issue;
      for (int k = 1; k < NUM_STAGES; k++) trk_vld[k] <= trk_vld[k-1];
    end
  end

  always_ff @(posedge clk) begin
    trk_rd[0]  <= id_rd;
    trk_rwe[0] <= id_rwe;
    for (int k = 1; k < NUM_STAGES; k++) begin
      trk_rd[k]  <= trk_rd[k-1];
      trk_rwe[k] <= trk_rwe[k-1];
    end
  end

`ifdef OPERAND_FWD_STALL_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   stall_cnt <= '0;
    else if (stall) stall_cnt <= sat_inc(stall_cnt);
  end
`endif

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Scoreboard bench for operand_fwd_ctrl (XLEN=32, NUM_STAGES=2) with directed vectors.
module tb_operand_fwd_ctrl;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] L  = 7'b0000011;
  localparam logic [6:0] S  = 7'b0100011;
  localparam logic [6:0] B  = 7'b1100011;
  localparam logic [6:0] LU = 7'b0110111;
  localparam logic [6:0] AU = 7'b0010111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [6:0]  id_opcode = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_rwe = 1'b0;
  logic [31:0] id_rs1d = '0, id_rs2d = '0, id_pc = '0, id_imm = '0;
  logic [63:0] stg_data = '0;
  logic [1:0]  stg_ready = '0;
  logic        flush = 1'b0;
  logic        stall, issue;
  logic [31:0] rs1d_fwd, rs2d_fwd, op_a, op_b;
`ifdef OPERAND_FWD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  operand_fwd_ctrl #(.XLEN(32), .NUM_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rwe(id_rwe),
    .id_rs1d(id_rs1d), .id_rs2d(id_rs2d), .id_pc(id_pc), .id_imm(id_imm),
    .stg_data(stg_data), .stg_ready(stg_ready), .flush(flush),
    .stall(stall), .issue(issue), .rs1d_fwd(rs1d_fwd), .rs2d_fwd(rs2d_fwd),
    .op_a(op_a), .op_b(op_b)
`ifdef OPERAND_FWD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic        issue;
    logic [31:0] a, b, f1, f2;
    logic [3:0]  mask;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cnt_model = 0;

  function automatic void chk(input string nm, input string fld,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk(mon_e.name, "stall", {31'd0, stall}, {31'd0, mon_e.stall});
      chk(mon_e.name, "issue", {31'd0, issue}, {31'd0, mon_e.issue});
      if (mon_e.mask[0]) chk(mon_e.name, "op_a", op_a, mon_e.a);
      if (mon_e.mask[1]) chk(mon_e.name, "op_b", op_b, mon_e.b);
      if (mon_e.mask[2]) chk(mon_e.name, "rs1d_fwd", rs1d_fwd, mon_e.f1);
      if (mon_e.mask[3]) chk(mon_e.name, "rs2d_fwd", rs2d_fwd, mon_e.f2);
`ifdef OPERAND_FWD_STALL_CNT_EN
      chk(mon_e.name, "stall_cnt", stall_cnt, mon_e.cnt);
`endif
    end
  end

  task automatic step(input string nm, input logic rn, input logic v, input logic [6:0] opc,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic rwe, input logic [31:0] r1d, input logic [31:0] r2d,
                      input logic [31:0] pc, input logic [31:0] imm, input logic [1:0] rdy,
                      input logic [31:0] d0, input logic [31:0] d1, input logic fl,
                      input logic e_stall, input logic e_issue, input logic [31:0] e_a,
                      input logic [31:0] e_b, input logic [31:0] e_f1, input logic [31:0] e_f2,
                      input logic [3:0] mask);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = rn; id_valid = v; id_opcode = opc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rwe = rwe; id_rs1d = r1d; id_rs2d = r2d; id_pc = pc; id_imm = imm;
    stg_ready = rdy; stg_data = {d1, d0}; flush = fl;
    if (!rn) cnt_model = 0;
    e.name = nm; e.stall = e_stall; e.issue = e_issue; e.a = e_a; e.b = e_b;
    e.f1 = e_f1; e.f2 = e_f2; e.mask = mask; e.cnt = cnt_model;
    q.push_back(e);
    if (rn && e_stall) cnt_model++;
  endtask

  initial begin
    //   name               rn v  opc rs1 rs2 rd rwe rs1d      rs2d      pc     imm           rdy    d0      d1      fl  st is a         b             f1      f2      mask
    step("rst",             0, 1, R,  5,  6,  5, 1, 32'h11,   32'h22,   0,     0,            2'b00, 0,      0,      0,  0, 1, 32'h11,   32'h22,       32'h11, 32'h22, 4'hF);
    step("idle",            1, 0, R,  0,  0,  0, 0, 32'h1,    32'h2,    0,     0,            2'b00, 0,      0,      0,  0, 0, 32'h1,    32'h2,        32'h1,  32'h2,  4'hF);
    step("add_x5",          1, 1, R,  1,  2,  5, 1, 32'h100,  32'h200,  0,     0,            2'b00, 0,      0,      0,  0, 1, 32'h100,  32'h200,      32'h100, 32'h200, 4'hF);
    step("fwd_s0",          1, 1, R,  5,  6,  8, 1, 32'hDEAD, 32'h66,   0,     0,            2'b01, 32'h1234, 32'h9999, 0, 0, 1, 32'h1234, 32'h66,    32'h1234, 32'h66, 4'hF);
    step("itype_rs2_unused",1, 1, I,  0,  8,  7, 1, 32'h10,   32'h0,    0,     32'h5,        2'b00, 0,      0,      0,  0, 1, 32'h10,   32'h5,        32'h10, 0,      4'h7);
    step("add_x7",          1, 1, R,  0,  0,  7, 1, 32'h3,    32'h4,    0,     0,            2'b00, 0,      0,      0,  0, 1, 32'h3,    32'h4,        32'h3,  32'h4,  4'hF);
    step("youngest",        1, 1, R,  0,  7,  9, 1, 32'h5,    32'h77,   0,     0,            2'b11, 32'hAAAA, 32'hBBBB, 0, 0, 1, 32'h5,  32'hAAAA,     32'h5,  32'hAAAA, 4'hF);
    step("rs1_eq_rs2",      1, 1, B,  9,  9,  0, 0, 32'h1,    32'h2,    32'h400, 32'h20,     2'b11, 32'hC0DE, 32'h1, 0,  0, 1, 32'h400,  32'h20,       32'hC0DE, 32'hC0DE, 4'hF);
    step("ld_issue",        1, 1, L,  0,  0,  3, 1, 32'h1000, 32'h0,    0,     32'h8,        2'b00, 0,      0,      0,  0, 1, 32'h1000, 32'h8,        32'h1000, 0,    4'hF);
    step("ld_use_stall",    1, 1, R,  3,  0,  4, 1, 32'h33,   32'h0,    0,     0,            2'b00, 0,      0,      0,  1, 0, 0,        0,            0,      0,      4'h0);
    step("ld_use_fwd",      1, 1, R,  3,  0,  4, 1, 32'h33,   32'h0,    0,     0,            2'b10, 32'hFFFF, 32'h5A5A, 0, 0, 1, 32'h5A5A, 32'h0,     32'h5A5A, 0,    4'hF);
    step("x0_wr",           1, 1, R,  0,  0,  0, 1, 32'h41,   32'h42,   0,     0,            2'b00, 0,      0,      0,  0, 1, 32'h41,   32'h42,       32'h41, 32'h42, 4'hF);
    step("x0_nofwd",        1, 1, R,  0,  0, 10, 1, 32'h31,   32'h32,   0,     0,            2'b11, 32'hEEEE, 32'hDDDD, 0, 0, 1, 32'h31, 32'h32,       32'h31, 32'h32, 4'hF);
    step("ld_x11",          1, 1, L, 10,  0, 11, 1, 32'h0,    32'h0,    0,     32'h4,        2'b01, 32'h2000, 32'h0, 0,  0, 1, 32'h2000, 32'h4,        32'h2000, 0,    4'hF);
    step("lui_nohaz",       1, 1, LU,11, 11, 12, 1, 32'h0,    32'h0,    0,     32'hABCDE000, 2'b00, 0,      0,      0,  0, 1, 0,        32'hABCDE000, 0,      0,      4'h2);
    step("auipc",           1, 1, AU, 0,  0, 13, 1, 32'h0,    32'h0,    32'h80, 32'h1000,    2'b00, 0,      0,      0,  0, 1, 32'h80,   32'h1000,     0,      0,      4'hF);
    step("ld_x14",          1, 1, L,  0,  0, 14, 1, 32'h0,    32'h0,    0,     0,            2'b00, 0,      0,      0,  0, 1, 0,        0,            0,      0,      4'hF);
    step("flush_stall",     1, 1, R, 14,  0, 15, 1, 32'h0,    32'h0,    0,     0,            2'b00, 0,      0,      1,  0, 0, 0,        0,            0,      0,      4'h0);
    step("post_flush",      1, 1, R, 14, 13, 15, 1, 32'h141,  32'h131,  0,     0,            2'b11, 32'hF0, 32'hF1, 0,  0, 1, 32'h141,  32'h131,      32'h141, 32'h131, 4'hF);
    step("ld_x16",          1, 1, L,  0,  0, 16, 1, 32'h0,    32'h0,    0,     0,            2'b00, 0,      0,      0,  0, 1, 0,        0,            0,      0,      4'hF);
    step("stall2",          1, 1, R, 16,  0, 17, 1, 32'h160,  32'h0,    0,     0,            2'b00, 0,      0,      0,  1, 0, 0,        0,            0,      0,      4'h0);
    step("async_rst",       0, 1, R, 16,  0, 17, 1, 32'h161,  32'h0,    0,     0,            2'b00, 0,      0,      0,  0, 1, 32'h161,  32'h0,        32'h161, 0,     4'hF);
    step("post_rst",        1, 1, R, 16,  0, 17, 1, 32'h162,  32'h0,    0,     0,            2'b00, 0,      0,      0,  0, 1, 32'h162,  32'h0,        32'h162, 0,     4'hF);
    step("store_fwd",       1, 1, S,  0, 17,  0, 0, 32'h200,  32'h0,    0,     32'hC,        2'b01, 32'h5555, 32'h0, 0,  0, 1, 32'h200,  32'hC,        32'h200, 32'h5555, 4'hF);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
